// File: rtl/sram_arbiter.sv
// Three-client request arbiter (video, DMA, CPU) in front of the SRAM controller.
// Each client owns a one-entry slot; one slot is granted per controller cyc pulse,
// and read data is routed back to its owner through an in-order tag pipeline.
module sram_arbiter #(
  parameter int unsigned RD_LAT     = 6,
  parameter int unsigned CPU_STARVE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic        vid_busy,
  output logic        vid_strb,
  input  logic        dma_req,
  input  logic        dma_rnw,
  input  logic [20:0] dma_addr,
  input  logic [15:0] dma_wrdata,
  input  logic [1:0]  dma_bsel,
  output logic        dma_busy,
  output logic        dma_strb,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic [15:0] cpu_wrdata,
  input  logic [1:0]  cpu_bsel,
  output logic        cpu_busy,
  output logic        cpu_strb,
  output logic [15:0] rd_data,
  output logic        req,
  output logic        rnw,
  output logic [20:0] addr,
  output logic [15:0] wrdata,
  output logic [1:0]  bsel,
  input  logic [15:0] sram_do
);

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  typedef struct packed {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wrdata;
    logic [BW-1:0] bsel;
  } slot_t;

  logic [AW-1:0] vid_addr_q;
  slot_t         dma_q;
  slot_t         cpu_q;
  logic [CW-1:0] starve_cnt;
  owner_t        tag_pipe [RD_LAT];

  owner_t        sel;
  logic          grant;
  logic          cpu_prio;
  owner_t        push_tag;
  owner_t        wr_own;
  owner_t        ret_tag;

  // Grant selection: starved CPU first, then video, DMA, CPU.
  always_comb begin
    sel      = OWN_NONE;
    cpu_prio = cpu_busy && (starve_cnt == CW'(CPU_STARVE));
    if (cpu_prio)      sel = OWN_CPU;
    else if (vid_busy) sel = OWN_VID;
    else if (dma_busy) sel = OWN_DMA;
    else if (cpu_busy) sel = OWN_CPU;
  end

  // Controller-facing mux from the selected slot; zero when nothing is pending.
  always_comb begin
    req    = 1'b0;
    rnw    = 1'b0;
    addr   = '0;
    wrdata = '0;
    bsel   = '0;
    unique case (sel)
      OWN_VID: begin
        req  = 1'b1;
        rnw  = 1'b1;
        addr = vid_addr_q;
        bsel = 2'b11;
      end
      OWN_DMA: begin
        req    = 1'b1;
        rnw    = dma_q.rnw;
        addr   = dma_q.addr;
        wrdata = dma_q.wrdata;
        bsel   = dma_q.bsel;
      end
      OWN_CPU: begin
        req    = 1'b1;
        rnw    = cpu_q.rnw;
        addr   = cpu_q.addr;
        wrdata = cpu_q.wrdata;
        bsel   = cpu_q.bsel;
      end
      default: ;
    endcase
  end

  // Grant event and what it produces: a read tag or an immediate write completion.
  always_comb begin
    grant    = cyc && req;
    push_tag = OWN_NONE;
    wr_own   = OWN_NONE;
    if (grant) begin
      if (rnw) push_tag = sel;
      else     wr_own   = sel;
    end
    ret_tag = tag_pipe[RD_LAT-1];
  end

  // Video slot: address only, always a full-word read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_busy   <= 1'b0;
      vid_addr_q <= '0;
    end else if (grant && sel == OWN_VID) begin
      vid_busy <= 1'b0;
    end else if (vid_req && !vid_busy) begin
      vid_busy   <= 1'b1;
      vid_addr_q <= vid_addr;
    end
  end

  // DMA slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_busy <= 1'b0;
      dma_q    <= '0;
    end else if (grant && sel == OWN_DMA) begin
      dma_busy <= 1'b0;
    end else if (dma_req && !dma_busy) begin
      dma_busy <= 1'b1;
      dma_q    <= '{rnw: dma_rnw, addr: dma_addr, wrdata: dma_wrdata, bsel: dma_bsel};
    end
  end

  // CPU slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_busy <= 1'b0;
      cpu_q    <= '0;
    end else if (grant && sel == OWN_CPU) begin
      cpu_busy <= 1'b0;
    end else if (cpu_req && !cpu_busy) begin
      cpu_busy <= 1'b1;
      cpu_q    <= '{rnw: cpu_rnw, addr: cpu_addr, wrdata: cpu_wrdata, bsel: cpu_bsel};
    end
  end

  // CPU starvation counter: counts grants lost while the CPU waits, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (sel == OWN_CPU)
        starve_cnt <= '0;
      else if (cpu_busy && starve_cnt < CW'(CPU_STARVE))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Read-return tag pipeline, advancing every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= OWN_NONE;
    end else begin
      tag_pipe[0] <= push_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Completion strobes and read data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_strb <= 1'b0;
      dma_strb <= 1'b0;
      cpu_strb <= 1'b0;
      rd_data  <= '0;
    end else begin
      vid_strb <= (ret_tag == OWN_VID);
      dma_strb <= (ret_tag == OWN_DMA) || (wr_own == OWN_DMA);
      cpu_strb <= (ret_tag == OWN_CPU) || (wr_own == OWN_CPU);
      if (ret_tag != OWN_NONE) rd_data <= sram_do;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle vector table plus hand-written sequences
// for read latency, starvation, overlapping reads and mid-operation reset.
module tb_sram_arbiter;

  localparam int unsigned RD_LAT     = 6;
  localparam int unsigned CPU_STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc;
  logic        vid_req;
  logic [20:0] vid_addr;
  logic        vid_busy, vid_strb;
  logic        dma_req, dma_rnw;
  logic [20:0] dma_addr;
  logic [15:0] dma_wrdata;
  logic [1:0]  dma_bsel;
  logic        dma_busy, dma_strb;
  logic        cpu_req, cpu_rnw;
  logic [20:0] cpu_addr;
  logic [15:0] cpu_wrdata;
  logic [1:0]  cpu_bsel;
  logic        cpu_busy, cpu_strb;
  logic [15:0] rd_data;
  logic        req, rnw;
  logic [20:0] addr;
  logic [15:0] wrdata;
  logic [1:0]  bsel;
  logic [15:0] sram_do;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.RD_LAT(RD_LAT), .CPU_STARVE(CPU_STARVE)) dut (
    .clk(clk), .rst_n(rst_n), .cyc(cyc),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_busy(vid_busy), .vid_strb(vid_strb),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wrdata(dma_wrdata),
    .dma_bsel(dma_bsel), .dma_busy(dma_busy), .dma_strb(dma_strb),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
    .cpu_bsel(cpu_bsel), .cpu_busy(cpu_busy), .cpu_strb(cpu_strb),
    .rd_data(rd_data), .req(req), .rnw(rnw), .addr(addr), .wrdata(wrdata), .bsel(bsel),
    .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  rq;      // {vid, dma, cpu}
    logic [20:0] va;
    logic        drnw;
    logic [20:0] da;
    logic [15:0] dwd;
    logic [1:0]  dbs;
    logic        crnw;
    logic [20:0] ca;
    logic [15:0] cwd;
    logic [1:0]  cbs;
    logic        cyc;
    logic [15:0] sdo;
    logic [2:0]  e_busy;  // {vid, dma, cpu}
    logic [2:0]  e_strb;  // {vid, dma, cpu}
    logic        e_req;
    logic        e_rnw;
    logic [20:0] e_addr;
    logic [15:0] e_wd;
    logic [1:0]  e_bs;
    logic [15:0] e_rd;
    logic [3:0]  e_starve;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cyc = 0; vid_req = 0; vid_addr = '0;
    dma_req = 0; dma_rnw = 0; dma_addr = '0; dma_wrdata = '0; dma_bsel = '0;
    cpu_req = 0; cpu_rnw = 0; cpu_addr = '0; cpu_wrdata = '0; cpu_bsel = '0;
    sram_do = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic apply_vec(input vec_t v);
    {vid_req, dma_req, cpu_req} = v.rq;
    vid_addr = v.va;
    dma_rnw = v.drnw; dma_addr = v.da; dma_wrdata = v.dwd; dma_bsel = v.dbs;
    cpu_rnw = v.crnw; cpu_addr = v.ca; cpu_wrdata = v.cwd; cpu_bsel = v.cbs;
    cyc = v.cyc; sram_do = v.sdo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // rq, va, drnw, da, dwd, dbs, crnw, ca, cwd, cbs, cyc, sdo | busy, strb, req, rnw, addr, wd, bs, rd, starve
    vt[0]  = '{3'b010, 21'h0, 1'b0, 21'h000100, 16'hBEEF, 2'b10, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 16'h0,
               3'b010, 3'b000, 1'b1, 1'b0, 21'h000100, 16'hBEEF, 2'b10, 16'h0, 4'd0};
    vt[1]  = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b1, 16'h0,
               3'b000, 3'b010, 1'b0, 1'b0, 21'h0, 16'h0, 2'b00, 16'h0, 4'd0};
    vt[2]  = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 16'h0,
               3'b000, 3'b000, 1'b0, 1'b0, 21'h0, 16'h0, 2'b00, 16'h0, 4'd0};
    vt[3]  = '{3'b111, 21'h000200, 1'b1, 21'h000300, 16'h0, 2'b01, 1'b0, 21'h000400, 16'h1234, 2'b11, 1'b0, 16'h0,
               3'b111, 3'b000, 1'b1, 1'b1, 21'h000200, 16'h0, 2'b11, 16'h0, 4'd0};
    vt[4]  = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b1, 16'h0,
               3'b011, 3'b000, 1'b1, 1'b1, 21'h000300, 16'h0, 2'b01, 16'h0, 4'd1};
    vt[5]  = '{3'b010, 21'h0, 1'b0, 21'h07FFFF, 16'hFFFF, 2'b11, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 16'h0,
               3'b011, 3'b000, 1'b1, 1'b1, 21'h000300, 16'h0, 2'b01, 16'h0, 4'd1};
    vt[6]  = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b1, 16'h0,
               3'b001, 3'b000, 1'b1, 1'b0, 21'h000400, 16'h1234, 2'b11, 16'h0, 4'd2};
    vt[7]  = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b1, 16'hDEAD,
               3'b000, 3'b001, 1'b0, 1'b0, 21'h0, 16'h0, 2'b00, 16'h0, 4'd0};
    vt[8]  = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b1, 16'h0,
               3'b000, 3'b000, 1'b0, 1'b0, 21'h0, 16'h0, 2'b00, 16'h0, 4'd0};
    vt[9]  = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 16'h0,
               3'b000, 3'b000, 1'b0, 1'b0, 21'h0, 16'h0, 2'b00, 16'h0, 4'd0};
    vt[10] = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 16'h1111,
               3'b000, 3'b100, 1'b0, 1'b0, 21'h0, 16'h0, 2'b00, 16'h1111, 4'd0};
    vt[11] = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 16'h2222,
               3'b000, 3'b000, 1'b0, 1'b0, 21'h0, 16'h0, 2'b00, 16'h1111, 4'd0};
    vt[12] = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 16'h3333,
               3'b000, 3'b010, 1'b0, 1'b0, 21'h0, 16'h0, 2'b00, 16'h3333, 4'd0};
    vt[13] = '{3'b000, 21'h0, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 21'h0, 16'h0, 2'b00, 1'b0, 16'h0,
               3'b000, 3'b000, 1'b0, 1'b0, 21'h0, 16'h0, 2'b00, 16'h3333, 4'd0};

    // Reset state.
    clear_inputs();
    rst_n = 0;
    step();
    step();
    chk("rst_busy", {29'd0, vid_busy, dma_busy, cpu_busy}, 32'd0);
    chk("rst_strb", {29'd0, vid_strb, dma_strb, cpu_strb}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", {11'd0, addr}, 32'd0);
    chk("rst_wrdata_bsel_rnw", {13'd0, wrdata, bsel, rnw}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    rst_n = 1;

    // DMA write, priority ordering, busy-ignore, overlapping vid/dma reads.
    for (int i = 0; i < NV; i++) begin
      apply_vec(vt[i]);
      step();
      chk($sformatf("v%0d_busy", i), {29'd0, vid_busy, dma_busy, cpu_busy}, {29'd0, vt[i].e_busy});
      chk($sformatf("v%0d_strb", i), {29'd0, vid_strb, dma_strb, cpu_strb}, {29'd0, vt[i].e_strb});
      chk($sformatf("v%0d_req", i), {30'd0, req, rnw}, {30'd0, vt[i].e_req, vt[i].e_rnw});
      chk($sformatf("v%0d_addr", i), {11'd0, addr}, {11'd0, vt[i].e_addr});
      chk($sformatf("v%0d_wd_bs", i), {14'd0, wrdata, bsel}, {14'd0, vt[i].e_wd, vt[i].e_bs});
      chk($sformatf("v%0d_rd", i), {16'd0, rd_data}, {16'd0, vt[i].e_rd});
      chk($sformatf("v%0d_starve", i), {28'd0, dut.starve_cnt}, {28'd0, vt[i].e_starve});
    end

    // CPU read latency.
    do_reset();
    sram_do = 16'hA55A;
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h012345;
    step();
    cpu_req = 0;
    chk("cpurd_req", {31'd0, req}, 32'd1);
    chk("cpurd_addr", {11'd0, addr}, 32'h012345);
    chk("cpurd_busy", {31'd0, cpu_busy}, 32'd1);
    cyc = 1;
    step();
    cyc = 0;
    chk("cpurd_busy_drop", {31'd0, cpu_busy}, 32'd0);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (cpu_strb) begin
        lat = k;
        break;
      end
    end
    chk("cpurd_latency", 32'(lat), 32'(RD_LAT));
    chk("cpurd_data", {16'd0, rd_data}, 32'h0000A55A);
    step();
    chk("cpurd_strb_one_clk", {31'd0, cpu_strb}, 32'd0);

    // CPU starvation against continuous video traffic.
    do_reset();
    vid_req = 1; vid_addr = 21'h000055;
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h0AAAAA;
    step();
    cpu_req = 0;
    chk("stv_vid_first", {11'd0, addr}, 32'h000055);
    for (int n = 1; n <= 5; n++) begin
      if (n == 5) begin
        chk("stv_cpu_selected", {11'd0, addr}, 32'h0AAAAA);
        chk("stv_vid_pending", {31'd0, vid_busy}, 32'd1);
      end
      cyc = 1;
      step();
      cyc = 0;
      if (n < 5) chk($sformatf("stv_g%0d", n), {30'd0, vid_busy, cpu_busy}, 32'b01);
      else       chk("stv_g5_cpu", {30'd0, vid_busy, cpu_busy}, 32'b10);
      step();
      step();
    end
    chk("stv_cnt_cleared", {28'd0, dut.starve_cnt}, 32'd0);
    vid_req = 0;

    // Overlapping reads: vid then dma three clocks later.
    do_reset();
    vid_req = 1; vid_addr = 21'h000010;
    step();
    vid_req = 0; cyc = 1;
    step();
    cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      sram_do = 16'hC000 + 16'(k);
      dma_req = (k == 1); dma_rnw = 1; dma_addr = 21'h000020;
      cyc = (k == 3);
      step();
      chk($sformatf("ovl_k%0d_strb", k), {30'd0, vid_strb, dma_strb},
          {30'd0, (k == 6), (k == 9)});
      if (k == 6) chk("ovl_vid_data", {16'd0, rd_data}, 32'h0000C006);
      if (k == 9) chk("ovl_dma_data", {16'd0, rd_data}, 32'h0000C009);
    end
    dma_req = 0; cyc = 0;

    // Reset mid-operation: read tag in flight, CPU slot full.
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h000777;
    step();
    cpu_req = 0; cyc = 1;
    step();
    cyc = 0; cpu_req = 1;
    step();
    cpu_req = 0;
    chk("mid_pre_busy", {31'd0, cpu_busy}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", {29'd0, vid_busy, dma_busy, cpu_busy}, 32'd0);
    chk("mid_rst_req", {31'd0, req}, 32'd0);
    chk("mid_rst_rd", {16'd0, rd_data}, 32'd0);
    step();
    rst_n = 1;
    sram_do = 16'h7777;
    for (int k = 0; k < int'(RD_LAT) + 2; k++) begin
      step();
      chk($sformatf("mid_post_k%0d", k), {28'd0, vid_strb, dma_strb, cpu_strb, req}, 32'd0);
    end
    chk("mid_post_rd", {16'd0, rd_data}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Request arbiter directly upstream of the SRAM controller.
- Collects memory requests from three clients: video fetch (read-only), DMA and CPU. Each client gets a one-entry holding slot.
- On each controller `cyc` pulse it presents one granted request on the controller's req/addr/wrdata/bsel/rnw inputs.
- Routes the controller's `sram_do` read data back to the owning client with a completion strobe.

Parameters:
- RD_LAT, 6: clocks from the granting `cyc` edge to the edge where `sram_do` holds that read's data (range 1..15).
- CPU_STARVE, 4: number of consecutive lost `cyc` arbitrations after which a pending CPU request gets top priority (range 1..15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cyc  in  1  one-clock pulse: the controller samples req/addr/wrdata/bsel/rnw on this edge.
- vid_req  in  1  video read request strobe.
- vid_addr  in  21  video word address.
- vid_busy  out  1  video slot full.
- vid_strb  out  1  video read data valid (one clock).
- dma_req  in  1  DMA request strobe.
- dma_rnw  in  1  DMA 1=read, 0=write.
- dma_addr  in  21  DMA address.
- dma_wrdata  in  16  DMA write data.
- dma_bsel  in  2  DMA byte select.
- dma_busy  out  1  DMA slot full.
- dma_strb  out  1  DMA completion (read data valid or write granted).
- cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_bsel  in  1/1/21/16/2  CPU request, same meaning as DMA.
- cpu_busy  out  1  CPU slot full.
- cpu_strb  out  1  CPU completion.
- rd_data  out  16  read data; valid while any *_strb is high.
- req  out  1  to controller: a request is presented.
- rnw  out  1  to controller.
- addr  out  21  to controller.
- wrdata  out  16  to controller.
- bsel  out  2  to controller.
- sram_do  in  16  read data from controller.

Behaviour:
- Reset (async, rst_n=0):
  - All slots empty, so every *_busy=0.
  - All *_strb=0, rd_data=0, starvation counter=0, read-return pipeline cleared.
  - req=0; addr, wrdata, bsel and rnw all 0.
- Slot load:
  - On posedge, if x_req=1 and x_busy=0, the slot latches addr/rnw/wrdata/bsel and sets busy.
  - A request while busy=1 is ignored; the client must retry.
  - The video slot always loads rnw=1 and bsel=2'b11.
- Grant selection (combinational from slot state and starvation flag), priority highest first:
  - CPU, if the CPU slot is full and starve_cnt==CPU_STARVE.
  - Video.
  - DMA.
  - CPU.
- Controller outputs:
  - req=1 when any slot is full.
  - addr/rnw/wrdata/bsel are muxed from the currently selected slot.
  - When no slot is full, all these outputs are 0.
- Grant event: on a clk edge with cyc=1 and req=1:
  - The selected slot is cleared; its busy drops on the next clock.
  - A new request from that client is accepted no earlier than the clock after busy falls.
  - A slot load and a grant of the same slot never coincide, because busy gates the load.
- Starvation counter:
  - On a grant event with the CPU slot full and CPU not granted: starve_cnt increments, saturating at CPU_STARVE.
  - On a CPU grant: starve_cnt resets to 0.
  - Unchanged otherwise.
- Write completion: owner x_strb pulses exactly one clock, on the clock after the grant edge. rd_data is unchanged.
- Read return:
  - A grant of a read pushes a 2-bit owner tag (0=none, 1=vid, 2=dma, 3=cpu) into an RD_LAT-deep shift pipeline, advancing every clock.
  - On the edge where the tag reaches the end: rd_data<=sram_do, and the owner's strb=1 for one clock.
  - Overlapping reads are supported; tags retire in order.
- Simultaneous completion: a write strobe and a read return for different clients on the same clock are both asserted; rd_data belongs to the read owner.
- Same-client completion collision: a write strobe and read return for the same client on the same clock cannot arise, because each client has only one slot outstanding.
- cyc with req=0: no state change; starve_cnt holds.
- Client requests are not acknowledged until the grant. Clients do not drive the memory bus between slot load and grant.

Test Plan:
- Reset: rst_n low mid-operation with the CPU slot full and a read tag in the pipeline → busy=0, req=0, no strobe after release, rd_data=0.
- CPU read: cpu_req with addr=21'h012345, rnw=1 → req=1 and addr=21'h012345. After the cyc grant, cpu_busy drops next clock. cpu_strb goes high exactly RD_LAT clocks after the grant edge, with rd_data equal to sram_do then (drive 16'hA55A).
- DMA write: dma_req with rnw=0, wrdata=16'hBEEF, bsel=2'b10 → presented with bsel=2'b10. dma_strb pulses on the clock after the cyc grant; no read tag is pushed.
- Priority: all three slots loaded, then three cyc pulses → grants in order vid, dma, cpu. starve_cnt reaches 2, then returns to 0.
- Starvation: CPU_STARVE=4, CPU slot held full, video re-requesting every slot-free clock → CPU granted on the 5th cyc, ahead of the pending video.
- Overlap: video read granted, then DMA read granted 3 clocks later (RD_LAT=6) → vid_strb then dma_strb, 3 clocks apart, each with that clock's sram_do.
